// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and its storage array.
package dmem_pkg;

    localparam int WORD_W = 32;

    // Responder FSM encoding.
    typedef logic [1:0] dmem_state_t;
    localparam dmem_state_t ST_IDLE = 2'd0;
    localparam dmem_state_t ST_WAIT = 2'd1;
    localparam dmem_state_t ST_RESP = 2'd2;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array with registered, read-first output.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
        rdata_o <= mem[idx_i];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches a MEM-stage request, waits LATENCY cycles,
// then commits the write or returns read data with a one-cycle acknowledge.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int         IDX_W    = idx_width(DEPTH_WORDS);
    localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
            $error("data_mem_responder: LATENCY must be within 0..15");
        end
        if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || IDX_W > 29) begin : g_bad_depth
            $error("data_mem_responder: DEPTH_WORDS must be a power of two in 2..2^29");
        end
    endgenerate

    dmem_state_t       state_q;
    logic [3:0]        cnt_q;
    logic              accept;
    logic              we_p0;
    logic [WORD_W-1:0] addr_p0;
    logic [WORD_W-1:0] wdata_p0;
    logic [WORD_W-1:0] rdata_p1;
    logic              addr_err;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_idx;

    assign accept = req_i && (state_q == ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        if (LATENCY > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= LAT_LOAD;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stage p0: request captured at the accept edge and held until the ack.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_p0    <= we_i;
            addr_p0  <= addr_i;
            wdata_p0 <= wdata_i;
        end
    end

    assign addr_err = (addr_p0[1:0] != 2'b00) ||
                      (addr_p0[WORD_W-1:IDX_W+2] != '0);

    // In IDLE the live address drives the array so a zero-latency read has
    // its word ready on the edge that enters RESP.
    assign arr_idx = (state_q == ST_IDLE) ? addr_i[IDX_W+1:2] : addr_p0[IDX_W+1:2];
    assign arr_we  = (state_q == ST_RESP) && we_p0 && !addr_err && !rst_i;

    // Stage p1: array output registered on the edge that enters RESP.
    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .idx_i   (arr_idx),
        .wdata_i (wdata_p0),
        .rdata_o (rdata_p1)
    );

    assign ready_o = (state_q == ST_IDLE);
    assign busy_o  = (state_q != ST_IDLE);
    assign ack_o   = (state_q == ST_RESP);
    assign err_o   = ack_o && addr_err;
    assign rdata_o = (ack_o && !we_p0 && !addr_err) ? rdata_p1 : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table-driven transactions scored on ack,
// plus stall, reset and zero-latency sequences.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, ack, err, busy;
    logic [31:0] rdata;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic        ready0, ack0, err0, busy0;
    logic [31:0] rdata0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .ready_o(ready), .ack_o(ack), .rdata_o(rdata),
        .err_o(err), .busy_o(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .wdata_i(wdata0), .ready_o(ready0), .ack_o(ack0), .rdata_o(rdata0),
        .err_o(err0), .busy_o(busy0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          due;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_acks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: each ack pops the oldest expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (ack === 1'b1) begin
            n_acks++;
            if (sb.size() == 0) begin
                chk("unexpected_ack_pending", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("ack_cycle[%0d]", e.tag), cyc, e.due);
                chk($sformatf("err[%0d]", e.tag), err, e.exp_err);
                chk($sformatf("rdata[%0d]", e.tag), rdata, e.exp_rdata);
            end
        end else if (sb.size() != 0 && sb[0].due < cyc) begin
            chk($sformatf("ack_timeout[%0d]", sb[0].tag), ack, 1);
            void'(sb.pop_front());
        end
        if (rst) sb.delete();
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic xe, input logic [31:0] xr, input int tag);
        bit done = 1'b0;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ready) begin
                sb.push_back('{xe, xr, cyc + LAT + 1, tag});
                done = 1'b1;
            end
        end
        if (!done) chk($sformatf("accept_timeout[%0d]", tag), ready, 1);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    vec_t        tbl [15];
    logic [31:0] sw_addr [3];
    logic [31:0] sw_data [3];
    int          acc [3];
    int          k;
    int          acks_before;
    int          a0;

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
        tbl[4]  = '{1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 1'b1, 32'h0};
        tbl[5]  = '{1'b1, 32'h0000_0400, 32'hAAAA_AAAA, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
        tbl[8]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0BAD_F00D};
        tbl[10] = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0};
        tbl[11] = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
        tbl[12] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1111_2222};
        tbl[14] = '{1'b1, 32'h0000_0024, 32'h5555_5555, 1'b0, 32'h0};
        sw_addr[0] = 32'h40; sw_addr[1] = 32'h44; sw_addr[2] = 32'h48;
        sw_data[0] = 32'hA1A1_A1A1; sw_data[1] = 32'hB2B2_B2B2; sw_data[2] = 32'hC3C3_C3C3;

        // Reset held two edges, then idle outputs.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_ready0", ready0, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++)
            issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rdata, i);
        drain();

        // Request held high across three writes.
        k = 0;
        req = 1'b1; we = 1'b1; addr = sw_addr[0]; wdata = sw_data[0];
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk);
            if (ready) begin
                sb.push_back('{1'b0, 32'h0, cyc + LAT + 1, 100 + k});
                acc[k] = cyc;
                if (k > 0) chk("stall_idle_busy", busy, 0);
                k++;
                @(posedge clk); #1;
                if (k < 3) begin
                    addr = sw_addr[k]; wdata = sw_data[k];
                end else begin
                    req = 1'b0;
                end
            end else begin
                chk("stall_busy", busy, 1);
            end
        end
        chk("stall_accepts", k, 3);
        chk("stall_interval1", acc[1] - acc[0], LAT + 2);
        chk("stall_interval2", acc[2] - acc[1], LAT + 2);
        drain();
        for (int i = 0; i < 3; i++) issue(1'b0, sw_addr[i], 32'h0, 1'b0, sw_data[i], 110 + i);
        drain();

        // Reset while a write to 0x20 is waiting.
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0, 200);
        acks_before = n_acks;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_no_ack", n_acks - acks_before, 0);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_busy", busy, 0);
        @(posedge clk); #1;
        issue(1'b0, 32'h20, 32'h0, 1'b0, 32'h1111_2222, 201);
        drain();

        // Reset coinciding with the RESP edge of a write to 0x24.
        issue(1'b1, 32'h24, 32'h6666_6666, 1'b0, 32'h0, 300);
        for (int i = 0; i < 20 && ack !== 1'b1; i++) @(negedge clk);
        chk("resp_rst_ack_seen", ack, 1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1'b0, 32'h24, 32'h0, 1'b0, 32'h5555_5555, 301);
        drain();

        // Zero-latency instance: write then back-to-back read of word 0.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h1234_5678;
        a0 = -1;
        for (int i = 0; i < 10 && a0 < 0; i++) begin
            @(negedge clk);
            if (ready0) a0 = cyc;
        end
        chk("l0_accept", ready0, 1);
        @(posedge clk); #1;
        we0 = 1'b0; wdata0 = 32'h0;
        @(negedge clk);
        chk("l0_wr_ack", ack0, 1);
        chk("l0_wr_err", err0, 0);
        chk("l0_wr_rdata", rdata0, 0);
        chk("l0_ready_low", ready0, 0);
        chk("l0_busy", busy0, 1);
        @(negedge clk);
        chk("l0_reaccept", ready0, 1);
        chk("l0_ack_pulse", ack0, 0);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("l0_rd_ack", ack0, 1);
        chk("l0_rd_data", rdata0, 32'h1234_5678);
        chk("l0_rd_err", err0, 0);
        @(negedge clk);
        chk("l0_idle_ack", ack0, 0);
        chk("l0_idle_rdata", rdata0, 0);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
